// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI-to-RAM bridge: frame command codes, FSM states
// and a small width helper used to size the serial payload.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RECV    = 2'b01,
    RD_WAIT = 2'b10,
    TX      = 2'b11
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_bridge_if.sv
// Serial-side signals of the SPI-to-RAM bridge; the master drives MOSI/SS_n,
// the bridge (slave) drives MISO and the err pulse.
interface spi_ram_bridge_if;
  logic MOSI;
  logic SS_n;
  logic MISO;
  logic err;

  modport master (output MOSI, output SS_n, input MISO, input err);
  modport slave  (input MOSI, input SS_n, output MISO, output err);
endinterface

// File: rtl/spi_ram_mem.sv
// Simple dual-port RAM for the bridge: synchronous write, registered read,
// contents deliberately left unreset so it maps onto block RAM.
module spi_ram_mem #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spi_ram_bridge.sv
// SPI-style serial front end to a small RAM: 2 command bits + payload per frame.
// Define SPI_RAM_BURST_EN to auto-increment address registers after each data access.
module spi_ram_bridge
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  spi_ram_bridge_if.slave  bus
);

  localparam int PW = max_int(ADDR_W, DATA_W);
  localparam int FW = PW + 2;
  localparam int CW = $clog2(FW + 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [DATA_W-1:0] MSB_MASK  = DATA_W'(1) << (DATA_W - 1);

  state_e            state_reg,   state_next;
  logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [FW-2:0]     shift_reg,   shift_next;
  logic [ADDR_W-1:0] waddr_reg,   waddr_next;
  logic [ADDR_W-1:0] raddr_reg,   raddr_next;
  logic [DATA_W-1:0] wdata_reg,   wdata_next;
  logic              wr_pend_reg, wr_pend_next;
  logic              rd_oor_reg,  rd_oor_next;
  logic              err_reg,     err_next;

  logic [FW-1:0]     shift_in;
  cmd_e              rx_cmd;
  logic              last_bit;
  logic              waddr_ok;
  logic              raddr_ok;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

`ifdef SPI_RAM_BURST_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] bump_addr(input logic [ADDR_W-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction
`endif

  // The bit sampled this edge completes the word together with the stored bits.
  assign shift_in = {shift_reg, bus.MOSI};
  assign rx_cmd   = cmd_e'(shift_in[FW-1:FW-2]);
  assign last_bit = (bit_cnt_reg == CW'(FW - 1));
  assign waddr_ok = ({1'b0, waddr_reg} < DEPTH_L);
  assign raddr_ok = ({1'b0, raddr_reg} < DEPTH_L);

  assign mem_we = wr_pend_reg && waddr_ok;
  assign mem_re = (state_reg == RD_WAIT) && raddr_ok;

  spi_ram_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr_reg),
    .wdata (wdata_reg),
    .re    (mem_re),
    .raddr (raddr_reg),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      waddr_reg   <= '0;
      raddr_reg   <= '0;
      wdata_reg   <= '0;
      wr_pend_reg <= 1'b0;
      rd_oor_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      waddr_reg   <= waddr_next;
      raddr_reg   <= raddr_next;
      wdata_reg   <= wdata_next;
      wr_pend_reg <= wr_pend_next;
      rd_oor_reg  <= rd_oor_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    waddr_next   = waddr_reg;
    raddr_next   = raddr_reg;
    wdata_next   = wdata_reg;
    wr_pend_next = 1'b0;
    rd_oor_next  = rd_oor_reg;
    err_next     = 1'b0;

    // A completed write frame commits one cycle later, independent of the FSM.
    if (wr_pend_reg) begin
      if (!waddr_ok) begin
        err_next = 1'b1;
      end
`ifdef SPI_RAM_BURST_EN
      waddr_next = bump_addr(waddr_reg);
`endif
    end

    unique case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        if (!bus.SS_n) begin
          state_next   = RECV;
          bit_cnt_next = CW'(1);
          shift_next   = {{(FW - 2){1'b0}}, bus.MOSI};
        end
      end

      RECV: begin
        if (bus.SS_n) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          shift_next   = '0;
          err_next     = 1'b1;
        end else if (last_bit) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          shift_next   = shift_in[FW-2:0];
          case (rx_cmd)
            CMD_WADDR: waddr_next = shift_in[ADDR_W-1:0];
            CMD_WDATA: begin
              wr_pend_next = 1'b1;
              wdata_next   = shift_in[DATA_W-1:0];
            end
            CMD_RADDR: raddr_next = shift_in[ADDR_W-1:0];
            CMD_RDATA: state_next = RD_WAIT;
          endcase
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
          shift_next   = shift_in[FW-2:0];
        end
      end

      RD_WAIT: begin
        bit_cnt_next = '0;
        if (bus.SS_n) begin
          state_next = IDLE;
        end else begin
          state_next  = TX;
          rd_oor_next = !raddr_ok;
          err_next    = !raddr_ok;
`ifdef SPI_RAM_BURST_EN
          raddr_next  = bump_addr(raddr_reg);
`endif
        end
      end

      TX: begin
        if (bus.SS_n || (bit_cnt_reg == CW'(DATA_W - 1))) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + CW'(1);
        end
      end
    endcase
  end

  // MISO is purely a function of registered state so reset silences it at once.
  assign bus.MISO = (state_reg == TX) && !rd_oor_reg &&
                    (|(mem_rdata & (MSB_MASK >> bit_cnt_reg)));
  assign bus.err  = err_reg;

endmodule

// File: tb/tb_spi_ram_bridge.sv
// Directed bench for spi_ram_bridge: three instances (default, MEM_DEPTH=200,
// 10-bit address / 16-bit data) driven one at a time through a shared MOSI line.
module tb_spi_ram_bridge;
  import spi_ram_pkg::*;

`ifdef SPI_RAM_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mosi;
  logic [2:0] ss_n;
  int         checks = 0;
  int         errors = 0;
  int         err_cnt [3] = '{0, 0, 0};

  spi_ram_bridge_if bus0 ();
  spi_ram_bridge_if bus1 ();
  spi_ram_bridge_if bus2 ();

  assign bus0.MOSI = mosi;
  assign bus1.MOSI = mosi;
  assign bus2.MOSI = mosi;
  assign bus0.SS_n = ss_n[0];
  assign bus1.SS_n = ss_n[1];
  assign bus2.SS_n = ss_n[2];

  spi_ram_bridge dut0 (.clk(clk), .rst(rst), .bus(bus0));
  spi_ram_bridge #(.MEM_DEPTH(200)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  spi_ram_bridge #(.ADDR_W(10), .DATA_W(16), .MEM_DEPTH(1024)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.err) err_cnt[0]++;
    if (bus1.err) err_cnt[1]++;
    if (bus2.err) err_cnt[2]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic miso_of(input int d);
    case (d)
      0:       return bus0.MISO;
      1:       return bus1.MISO;
      default: return bus2.MISO;
    endcase
  endfunction

  // Starts and ends on a falling edge; hold keeps SS_n low for a following read.
  task automatic send_frame(input int d, input logic [1:0] cmd, input logic [15:0] pay, input bit hold);
    int pw;
    pw = (d == 2) ? 16 : 8;
    for (int i = 0; i < pw + 2; i++) begin
      ss_n[d] = 1'b0;
      mosi    = (i < 2) ? cmd[1 - i] : pay[pw - 1 - (i - 2)];
      @(negedge clk);
    end
    mosi = 1'b0;
    if (!hold) begin
      ss_n[d] = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic write_word(input int d, input logic [15:0] addr, input logic [15:0] data);
    send_frame(d, 2'b00, addr, 1'b0);
    send_frame(d, 2'b01, data, 1'b0);
  endtask

  task automatic read_word(input int d, output logic [15:0] got);
    int dw;
    dw  = (d == 2) ? 16 : 8;
    got = '0;
    send_frame(d, 2'b11, 16'h0000, 1'b1);
    checks++;
    if (miso_of(d) !== 1'b0) begin
      errors++;
      $display("FAIL miso_rd_wait dut%0d: got %b expected 0", d, miso_of(d));
    end
    @(negedge clk);
    for (int i = 0; i < dw; i++) begin
      got[dw - 1 - i] = miso_of(d);
      @(negedge clk);
    end
    ss_n[d] = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_at(input int d, input logic [15:0] addr, output logic [15:0] got);
    send_frame(d, 2'b10, addr, 1'b0);
    read_word(d, got);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus0.MISO); end
    checks++;
    if (bus0.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus0.err); end
    checks++;
    if (dut0.state_reg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut0.state_reg, IDLE); end
    checks++;
    if (dut0.waddr_reg !== 8'h00) begin errors++; $display("FAIL reset_waddr: got %h expected 00", dut0.waddr_reg); end
    checks++;
    if (dut0.raddr_reg !== 8'h00) begin errors++; $display("FAIL reset_raddr: got %h expected 00", dut0.raddr_reg); end
    checks++;
    if (dut0.bit_cnt_reg !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %h expected 0", dut0.bit_cnt_reg); end
    checks++;
    if (dut0.shift_reg !== '0) begin errors++; $display("FAIL reset_shift: got %h expected 0", dut0.shift_reg); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] got;
    logic [7:0]  exp;
    int          e0;
    e0 = err_cnt[0];
    write_word(0, 16'h0012, 16'h00A5);
    write_word(0, 16'h0013, 16'h005C);
    write_word(0, 16'h0000, 16'h003C);
    read_at(0, 16'h0012, got);
    checks++;
    if (got[7:0] !== 8'hA5) begin errors++; $display("FAIL basic_read_12: got %h expected a5", got[7:0]); end
    // Bare read without reloading: same address, or the next one in burst mode.
    read_word(0, got);
    exp = BURST ? 8'h5C : 8'hA5;
    checks++;
    if (got[7:0] !== exp) begin errors++; $display("FAIL raddr_persist: got %h expected %h", got[7:0], exp); end
    read_at(0, 16'h0000, got);
    checks++;
    if (got[7:0] !== 8'h3C) begin errors++; $display("FAIL basic_read_00: got %h expected 3c", got[7:0]); end
    checks++;
    if (dut0.state_reg !== IDLE) begin errors++; $display("FAIL basic_state_after_tx: got %0d expected %0d", dut0.state_reg, IDLE); end
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt[0] - e0 !== 0) begin errors++; $display("FAIL basic_no_err: got %0d pulses expected 0", err_cnt[0] - e0); end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    int          e0;
    e0 = err_cnt[0];
    send_frame(0, 2'b00, 16'h0012, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ss_n[0] = 1'b0;
      mosi    = (i == 1);
      @(negedge clk);
    end
    ss_n[0] = 1'b1;
    mosi    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt[0] - e0 !== 1) begin errors++; $display("FAIL abort_err: got %0d pulses expected 1", err_cnt[0] - e0); end
    checks++;
    if (dut0.state_reg !== IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dut0.state_reg, IDLE); end
    read_at(0, 16'h0012, got);
    checks++;
    if (got[7:0] !== 8'hA5) begin errors++; $display("FAIL abort_ram_kept: got %h expected a5", got[7:0]); end
  endtask

  task automatic test_out_of_range();
    logic [15:0] got;
    int          e0;
    e0 = err_cnt[1];
    write_word(1, 16'h00C8, 16'h0033);
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt[1] - e0 !== 1) begin errors++; $display("FAIL oor_write_err: got %0d pulses expected 1", err_cnt[1] - e0); end
    e0 = err_cnt[1];
    read_at(1, 16'h00C8, got);
    repeat (2) @(negedge clk);
    checks++;
    if (got[7:0] !== 8'h00) begin errors++; $display("FAIL oor_read_data: got %h expected 00", got[7:0]); end
    checks++;
    if (err_cnt[1] - e0 !== 1) begin errors++; $display("FAIL oor_read_err: got %0d pulses expected 1", err_cnt[1] - e0); end
    e0 = err_cnt[1];
    write_word(1, 16'h00C7, 16'h005A);
    read_at(1, 16'h00C7, got);
    repeat (2) @(negedge clk);
    checks++;
    if (got[7:0] !== 8'h5A) begin errors++; $display("FAIL last_addr_data: got %h expected 5a", got[7:0]); end
    checks++;
    if (err_cnt[1] - e0 !== 0) begin errors++; $display("FAIL last_addr_no_err: got %0d pulses expected 0", err_cnt[1] - e0); end
  endtask

  task automatic test_burst();
    logic [15:0] got;
    logic [7:0]  exp;
    write_word(0, 16'h0000, 16'h0077);
    send_frame(0, 2'b00, 16'h00FF, 1'b0);
    send_frame(0, 2'b01, 16'h0011, 1'b0);
    send_frame(0, 2'b01, 16'h0022, 1'b0);
    read_at(0, 16'h00FF, got);
    exp = BURST ? 8'h11 : 8'h22;
    checks++;
    if (got[7:0] !== exp) begin errors++; $display("FAIL burst_ram_ff: got %h expected %h", got[7:0], exp); end
    read_at(0, 16'h0000, got);
    exp = BURST ? 8'h22 : 8'h77;
    checks++;
    if (got[7:0] !== exp) begin errors++; $display("FAIL burst_ram_00: got %h expected %h", got[7:0], exp); end
  endtask

  task automatic test_wide();
    logic [15:0] got;
    int          e0;
    e0 = err_cnt[2];
    write_word(2, 16'h03FF, 16'hBEEF);
    read_at(2, 16'h03FF, got);
    checks++;
    if (got !== 16'hBEEF) begin errors++; $display("FAIL wide_3ff: got %h expected beef", got); end
    // Upper payload bits beyond ADDR_W must be ignored.
    write_word(2, 16'hFC05, 16'h1234);
    read_at(2, 16'h0005, got);
    checks++;
    if (got !== 16'h1234) begin errors++; $display("FAIL wide_addr_trunc: got %h expected 1234", got); end
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt[2] - e0 !== 0) begin errors++; $display("FAIL wide_no_err: got %0d pulses expected 0", err_cnt[2] - e0); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] got;
    write_word(0, 16'h0005, 16'h00FF);
    send_frame(0, 2'b10, 16'h0005, 1'b0);
    send_frame(0, 2'b11, 16'h0000, 1'b1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.MISO !== 1'b1) begin errors++; $display("FAIL tx_bit3_before_rst: got %b expected 1", bus0.MISO); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus0.MISO !== 1'b0) begin errors++; $display("FAIL rst_tx_miso: got %b expected 0", bus0.MISO); end
    checks++;
    if (dut0.state_reg !== IDLE) begin errors++; $display("FAIL rst_tx_state: got %0d expected %0d", dut0.state_reg, IDLE); end
    checks++;
    if (dut0.waddr_reg !== 8'h00 || dut0.raddr_reg !== 8'h00) begin
      errors++;
      $display("FAIL rst_tx_addr: got waddr %h raddr %h expected 00 00", dut0.waddr_reg, dut0.raddr_reg);
    end
    @(negedge clk);
    rst     = 1'b0;
    ss_n[0] = 1'b1;
    @(negedge clk);
    read_at(0, 16'h0005, got);
    checks++;
    if (got[7:0] !== 8'hFF) begin errors++; $display("FAIL ram_survives_rst: got %h expected ff", got[7:0]); end
    // Reset one bit before the end of a write frame must not write.
    write_word(0, 16'h0020, 16'h0066);
    send_frame(0, 2'b00, 16'h0020, 1'b0);
    for (int i = 0; i < 9; i++) begin
      ss_n[0] = 1'b0;
      mosi    = (i == 1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    ss_n[0] = 1'b1;
    mosi    = 1'b0;
    @(negedge clk);
    read_at(0, 16'h0020, got);
    checks++;
    if (got[7:0] !== 8'h66) begin errors++; $display("FAIL rst_frame_no_write: got %h expected 66", got[7:0]); end
  endtask

  initial begin
    rst  = 1'b1;
    ss_n = 3'b111;
    mosi = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_abort();
    test_out_of_range();
    test_burst();
    test_wide();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_bridge.md
SPI_RAM_BRIDGE -- requirements
Module: spi_ram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, RAM word width in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of RAM words; legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port MOSI  input  1  serial data in, sampled on clk rising edge.
REQ-007 SHALL have port SS_n  input  1  active-low slave select; frame boundary.
REQ-008 SHALL have port MISO  output  1  serial read data out.
REQ-009 SHALL have port err  output  1  one-cycle pulse on aborted frame or out-of-range access.

Function
REQ-010 SHALL define PW = max(ADDR_W, DATA_W); frame = 2 command bits then PW payload bits, MSB first.
REQ-011 SHALL decode commands as 00 = load write address, 01 = write data, 10 = load read address, 11 = read data.
REQ-012 SHALL implement states IDLE, RECV, RD_WAIT, TX.
REQ-013 IDLE: SS_n=0 on a rising edge moves to RECV; that edge samples command bit 1 (the MSB).
REQ-014 RECV: shifts one bit per cycle; on the cycle the (2+PW)th bit is sampled, the frame is decoded and the state returns to IDLE, except for command 11.
REQ-015 Address payloads SHALL use the low ADDR_W bits; data payloads SHALL use the low DATA_W bits; upper payload bits are ignored.
REQ-016 Command 01 SHALL write the RAM at the write-address register in the cycle after the last bit.
REQ-017 Command 11 SHALL go to RD_WAIT for one cycle (RAM read), then to TX.
REQ-018 TX SHALL drive DATA_W bits on MISO, MSB first, one bit per cycle, then return to IDLE.
REQ-019 MISO SHALL be 0 in every state except TX.
REQ-020 SS_n=1 in any state other than IDLE SHALL return the state to IDLE on the next edge, discard the partial frame, perform no RAM write and pulse err if the state was RECV with bits received.
REQ-021 A write to address >= MEM_DEPTH SHALL be dropped and pulse err.
REQ-022 A read from address >= MEM_DEPTH SHALL return all-zero data and pulse err.
REQ-023 Address registers SHALL persist across frames until reloaded.

Reset
REQ-024 rst SHALL force state IDLE, MISO=0, err=0, both address registers 0, and the bit counter and shift register 0; RAM contents are not reset.
REQ-025 Assertion of rst mid-frame or mid-TX SHALL abort immediately with no RAM write.

Configuration
REQ-026 Macro SPI_RAM_BURST_EN defined: after each command 01 or 11, the corresponding address register SHALL increment, wrapping MEM_DEPTH-1 to 0.
REQ-027 SPI_RAM_BURST_EN undefined: address registers SHALL change only on commands 00/10 or reset.

Structure
REQ-028 Package spi_ram_pkg SHALL hold the command enum (CMD_WADDR, CMD_WDATA, CMD_RADDR, CMD_RDATA) and the state enum.
REQ-029 The RAM SHALL be sub-module spi_ram_mem (parameters ADDR_W, DATA_W, MEM_DEPTH; synchronous write, registered read).

Verification (defaults unless stated)
REQ-030 Frame 00_0x12, then frame 01_0xA5, then 10_0x12, then 11_0x00 -> after RD_WAIT, MISO = 1,0,1,0,0,1,0,1 over 8 cycles.
REQ-031 SS_n raised after 5 bits of a 01 frame -> err pulses once; state IDLE; RAM word unchanged.
REQ-032 MEM_DEPTH=200: 00_0xC8, then 01_0x33 -> err pulse, no write; 10_0xC8, then 11 -> MISO all 0, err pulse.
REQ-033 SPI_RAM_BURST_EN: 00_0xFF, then 01_0x11, then 01_0x22 -> RAM[255]=0x11, RAM[0]=0x22.
REQ-034 rst asserted in TX bit 3 -> MISO=0 the same cycle; state IDLE; address registers 0.
REQ-035 ADDR_W=10, DATA_W=16, MEM_DEPTH=1024: 18-bit frames write and read back 0xBEEF at address 0x3FF over 16 TX cycles.
